// File: rtl/tx_pkg.sv
// Shared types and constants for the UART transmit path.
package tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/tx_buffer_if.sv
// Byte handshake between game logic (master) and the transmit buffer (slave).
interface tx_buffer_if;
  import tx_pkg::*;

  logic [DATA_BITS-1:0] game_byte;
  logic                 send;
  logic                 tx_rdy;

  modport master (output game_byte, output send, input tx_rdy);
  modport slave  (input game_byte, input send, output tx_rdy);

endinterface

// File: rtl/baud_tick.sv
// Free-running bit timer: counts 0..CLKS_PER_BIT-1 and ticks on the terminal count.
module baud_tick #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/tx_buffer.sv
// One-entry holding register feeding an 8N1 UART serializer, LSB first.
module tx_buffer
  import tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic        clk,
  input  logic        rst,
  tx_buffer_if.slave  bus,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] hold, hold_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [BIT_W-1:0]     bit_idx, bit_idx_next;
  logic                 rdy, rdy_next;
  logic                 tx_next, busy_next, done_next;
  logic                 tick;
  logic                 load;

  // The timer restarts whenever the FSM changes state so every bit gets a full period.
  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state_next != state),
    .tick  (tick)
  );

  assign bus.tx_rdy = rdy;

  always_comb begin
    state_next   = state;
    hold_next    = hold;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    rdy_next     = rdy;
    tx_next      = tx;
    busy_next    = tx_busy;
    done_next    = 1'b0;
    load         = 1'b0;

    if (bus.send && rdy) begin
      hold_next = bus.game_byte;
      rdy_next  = 1'b0;
    end

    unique case (state)
      IDLE: begin
        load = !rdy;
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            shift_next   = shift >> 1;
            bit_idx_next = bit_idx + BIT_W'(1);
            tx_next      = shift[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          done_next = 1'b1;
          if (!rdy) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A send cannot coincide with a load: accepting needs an empty register, loading a full one.
    if (load) begin
      state_next   = START;
      shift_next   = hold;
      bit_idx_next = '0;
      rdy_next     = 1'b1;
      tx_next      = 1'b0;
      busy_next    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hold    <= '0;
      shift   <= '0;
      bit_idx <= '0;
      rdy     <= 1'b1;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_next;
      hold    <= hold_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      rdy     <= rdy_next;
      tx      <= tx_next;
      tx_busy <= busy_next;
      tx_done <= done_next;
    end
  end

endmodule
